// File: rtl/pc_pass_monitor.sv
// rtl/pc_pass_monitor.sv - fetch-PC test-completion monitor (PASS/FAIL/TIMEOUT)
// Optional PC history trace enabled by defining PC_HIST_EN.
module pc_pass_monitor #(
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 2000,
  parameter int HIST_DEPTH = 8,
  localparam int HIST_AW   = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  pc_current,
  input  logic               start,
  input  logic               clear,
  input  logic [ADDR_W-1:0]  pass_addr,
  input  logic [ADDR_W-1:0]  last_addr,
  input  logic               last_vld,
  input  logic [ADDR_W-1:0]  fail_addr,
  input  logic               fail_en,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycle_cnt,
  input  logic [HIST_AW-1:0] hist_idx,
  output logic [ADDR_W-1:0]  hist_pc
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   pass_q;
  logic [ADDR_W-1:0]   last_q;
  logic                last_vld_q;
  logic [ADDR_W-1:0]   fail_q;
  logic                fail_en_q;
  logic [ADDR_W-1:0]   prev_pc;
  logic [CNT_W-1:0]    cnt_inc;
  logic                hit_pass;
  logic                hit_fail;

  always_comb begin
    cnt_inc   = cycle_cnt + CNT_W'(1);
    hit_pass  = (pc_current == pass_q) && (!last_vld_q || (prev_pc == last_q));
    hit_fail  = fail_en_q && (pc_current == fail_q);
    state_nxt = state;
    if (start) begin
      state_nxt = S_RUN;
    end else if (clear) begin
      state_nxt = S_IDLE;
    end else if (state == S_RUN) begin
      // Fail outranks pass, and any match on the last budgeted cycle beats timeout.
      if (hit_fail)
        state_nxt = S_FAIL;
      else if (hit_pass)
        state_nxt = S_PASS;
      else if (cnt_inc == CNT_W'(MAX_CYCLES))
        state_nxt = S_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
      cycle_cnt  <= '0;
      pass_q     <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
      fail_q     <= '0;
      fail_en_q  <= 1'b0;
      prev_pc    <= '0;
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt == S_RUN);
      done    <= (state_nxt == S_PASS) || (state_nxt == S_FAIL) || (state_nxt == S_TIMEOUT);
      pass    <= (state_nxt == S_PASS);
      fail    <= (state_nxt == S_FAIL);
      timeout <= (state_nxt == S_TIMEOUT);
      if (start) begin
        pass_q     <= pass_addr;
        last_q     <= last_addr;
        last_vld_q <= last_vld;
        fail_q     <= fail_addr;
        fail_en_q  <= fail_en;
        prev_pc    <= pc_current;
        cycle_cnt  <= '0;
      end else if (clear) begin
        cycle_cnt  <= '0;
      end else if (state == S_RUN) begin
        cycle_cnt  <= cnt_inc;
        prev_pc    <= pc_current;
      end
    end
  end

`ifdef PC_HIST_EN
  logic [ADDR_W-1:0]  hist_mem [HIST_DEPTH];
  logic [HIST_AW-1:0] wptr;
  logic [HIST_AW-1:0] rptr;

  // Only PC changes are recorded, so tight loops do not flush the trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_mem[i] <= '0;
    end else if (start) begin
      wptr <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_mem[i] <= '0;
    end else if (!clear && (state == S_RUN) && (pc_current != prev_pc)) begin
      hist_mem[wptr] <= pc_current;
      wptr           <= (wptr == HIST_AW'(HIST_DEPTH - 1)) ? '0 : wptr + HIST_AW'(1);
    end
  end

  assign rptr    = wptr - HIST_AW'(1) - hist_idx;
  assign hist_pc = hist_mem[rptr];
`else
  logic unused_hist;
  assign unused_hist = ^hist_idx;
  assign hist_pc     = '0;
`endif

endmodule
